// File: rtl/io_bridge.sv
`timescale 1ns/1ps
// I/O bus bridge: decodes the CPU bus into per-slave slot windows, holds the strobe
// until the slave acknowledges or times out, and hosts the interrupt/error registers.
module io_bridge #(
  parameter int unsigned NSLAVES  = 4,
  parameter int unsigned AW       = 11,
  parameter int unsigned WIN_BITS = 8,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      read,
  input  logic                      write,
  input  logic [AW-1:0]             address,
  input  logic [31:0]               data_in,
  input  logic [3:0]                be,
  output logic [31:0]               data_out,
  output logic                      ack,
  output logic                      err,
  output logic [NSLAVES-1:0]        s_read,
  output logic [NSLAVES-1:0]        s_write,
  output logic [WIN_BITS-1:0]       s_address,
  output logic [31:0]               s_writedata,
  output logic [3:0]                s_be,
  input  logic [32*NSLAVES-1:0]     s_readdata,
  input  logic [NSLAVES-1:0]        s_ack,
  input  logic [NSLAVES-1:0]        irq_in,
  output logic                      irq
);

  localparam int unsigned SW       = AW - WIN_BITS;
  localparam int unsigned OW       = WIN_BITS - 2;
  localparam logic [SW:0] NS_LIM   = (SW+1)'(NSLAVES);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [31:0] BAD_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              r_state;
  logic [SW-1:0]       r_slot;
  logic                r_write;
  logic [15:0]         r_cnt;
  logic [31:0]         r_data_out;
  logic                r_ack;
  logic                r_err;
  logic [NSLAVES-1:0]  r_s_read;
  logic [NSLAVES-1:0]  r_s_write;
  logic [WIN_BITS-1:0] r_s_address;
  logic [31:0]         r_s_writedata;
  logic [3:0]          r_s_be;
  logic [NSLAVES-1:0]  r_irq_en;
  logic                r_err_to;
  logic                r_err_unm;
  logic [7:0]          r_err_slot;
  logic                r_irq;

  logic [SW-1:0]       w_slot;
  logic [OW-1:0]       w_off;
  logic                w_req, w_ext, w_int, w_sack, w_acc_to, w_unm_hit;
  logic [NSLAVES-1:0]  w_dec, w_sel;
  logic [NSLAVES-1:0]  w_rd_t [32];
  logic [31:0]         w_rdata, w_int_rd, w_be_mask;
  logic [1:0]          w_clr;
  logic [7:0]          w_err_slot;

  assign w_slot    = address[AW-1:WIN_BITS];
  assign w_off     = address[WIN_BITS-1:2];
  assign w_req     = read | write;
  assign w_ext     = {1'b0, w_slot} < NS_LIM;
  assign w_int     = &w_slot;
  assign w_be_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

  // Read-data mux built as a transposed AND-OR so each output bit is a flat reduction
  for (genvar g = 0; g < NSLAVES; g++) begin : g_slv
    assign w_dec[g] = (w_slot == SW'(g));
    assign w_sel[g] = (r_slot == SW'(g));
    for (genvar b = 0; b < 32; b++) begin : g_bit
      assign w_rd_t[b][g] = w_sel[g] & s_readdata[32*g+b];
    end
  end
  for (genvar b = 0; b < 32; b++) begin : g_or
    assign w_rdata[b] = |w_rd_t[b];
  end

  assign w_sack     = |(s_ack & w_sel);
  assign w_acc_to   = (r_state == ACCESS) && !w_sack && (r_cnt == TO_LAST);
  assign w_unm_hit  = (r_state == IDLE) && w_req && !w_ext && !w_int;
  assign w_clr      = ((r_state == IDLE) && write && w_int && (w_off == OW'(2)) && be[0])
                      ? data_in[1:0] : 2'b00;
  assign w_err_slot = (r_state == IDLE) ? 8'(w_slot) : 8'(r_slot);

  always_comb begin
    w_int_rd = '0;
    case (w_off)
      OW'(0):  w_int_rd[NSLAVES-1:0] = irq_in;
      OW'(1):  w_int_rd[NSLAVES-1:0] = r_irq_en;
      OW'(2):  w_int_rd = {16'h0, r_err_slot, 6'h0, r_err_unm, r_err_to};
      default: w_int_rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_slot        <= '0;
      r_write       <= 1'b0;
      r_cnt         <= '0;
      r_data_out    <= '0;
      r_ack         <= 1'b0;
      r_err         <= 1'b0;
      r_s_read      <= '0;
      r_s_write     <= '0;
      r_s_address   <= '0;
      r_s_writedata <= '0;
      r_s_be        <= '0;
      r_irq_en      <= '0;
      r_err_to      <= 1'b0;
      r_err_unm     <= 1'b0;
      r_err_slot    <= '0;
      r_irq         <= 1'b0;
    end else begin
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_irq     <= |(irq_in & r_irq_en);
      // Setting wins over a same-cycle write-1-to-clear
      r_err_to  <= (r_err_to  & ~w_clr[0]) | w_acc_to;
      r_err_unm <= (r_err_unm & ~w_clr[1]) | w_unm_hit;
      if (w_acc_to || w_unm_hit) r_err_slot <= w_err_slot;

      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_slot        <= w_slot;
            r_write       <= write;
            r_cnt         <= '0;
            r_s_address   <= address[WIN_BITS-1:0];
            r_s_writedata <= data_in;
            r_s_be        <= be;
            if (w_ext) begin
              r_s_read  <= write ? '0 : w_dec;
              r_s_write <= write ? w_dec : '0;
              r_state   <= ACCESS;
            end else begin
              r_ack   <= 1'b1;
              r_state <= RESP;
              if (w_int) begin
                if (!write) begin
                  r_data_out <= w_int_rd;
                end else if (w_off == OW'(1)) begin
                  r_irq_en <= (r_irq_en & ~w_be_mask[NSLAVES-1:0]) |
                              (data_in[NSLAVES-1:0] & w_be_mask[NSLAVES-1:0]);
                end
              end else begin
                r_err      <= 1'b1;
                r_data_out <= BAD_DATA;
              end
            end
          end
        end
        ACCESS: begin
          if (w_sack) begin
            r_s_read  <= '0;
            r_s_write <= '0;
            r_ack     <= 1'b1;
            if (!r_write) r_data_out <= w_rdata;
            r_state   <= RESP;
          end else if (r_cnt == TO_LAST) begin
            r_s_read   <= '0;
            r_s_write  <= '0;
            r_ack      <= 1'b1;
            r_err      <= 1'b1;
            r_data_out <= BAD_DATA;
            r_state    <= RESP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RESP: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_out    = r_data_out;
  assign ack         = r_ack;
  assign err         = r_err;
  assign s_read      = r_s_read;
  assign s_write     = r_s_write;
  assign s_address   = r_s_address;
  assign s_writedata = r_s_writedata;
  assign s_be        = r_s_be;
  assign irq         = r_irq;

endmodule

// File: doc/io_bridge.md
# io_bridge

Parametrised I/O bus bridge between the CPU data bus and up to NSLAVES memory-mapped peripherals (UARTs, SPI, LCD, switches). It decodes the address into fixed-size slot windows and holds a registered strobe to the selected slave until that slave acknowledges. It enforces a wait-state timeout, returns an error response for unmapped or timed-out accesses, and aggregates slave interrupts through an internal status/enable register slot.

## Interface
- NSLAVES, 4, number of external slave channels; must be ≤ 2^(AW-WIN_BITS)-1
- AW, 11, master byte-address width
- WIN_BITS, 8, log2 bytes per slot window; slot = address[AW-1:WIN_BITS]
- TIMEOUT, 255, max ACCESS cycles before bus error (1..65535)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- read  in  1  master read request, held until ack
- write  in  1  master write request, held until ack
- address  in  AW  master byte address
- data_in  in  32  master write data
- be  in  4  master byte enables
- data_out  out  32  registered read data, valid with ack
- ack  out  1  one-cycle completion pulse
- err  out  1  bus error, valid only with ack
- s_read  out  NSLAVES  per-slave read strobe (one-hot or zero)
- s_write  out  NSLAVES  per-slave write strobe (one-hot or zero)
- s_address  out  WIN_BITS  latched offset within slot
- s_writedata  out  32  latched write data
- s_be  out  4  latched byte enables
- s_readdata  in  32*NSLAVES  slave read data, slave i at bits [32i+31:32i]
- s_ack  in  NSLAVES  slave completion (level, sampled in ACCESS)
- irq_in  in  NSLAVES  synchronous level interrupts from slaves
- irq  out  1  registered OR of enabled pending interrupts

## Operation
- Decode: slot < NSLAVES → external slave; slot = all-ones → internal registers; anything else → unmapped.
- FSM states IDLE, ACCESS, RESP.
- IDLE: when read|write is high, latch address, data_in, be and direction (write wins if both are high) and the decoded slot.
  - External → ACCESS.
  - Internal or unmapped → RESP.
- ACCESS: s_read/s_write bit for the slot is held high and the wait counter increments each cycle.
  - s_ack[slot] high → capture s_readdata slot into data_out (reads only) → RESP.
  - Counter reaches TIMEOUT without ack → data_out=32'hDEADBEEF, flag timeout → RESP.
  - If s_ack and timeout coincide, ack wins.
- RESP: ack=1 for one cycle; err=1 for timeout or unmapped. Strobes are low. → IDLE.
- The master must drop read/write in the cycle after ack. A request still asserted in IDLE is a new access.
- Unmapped access: no slave strobe, data_out=32'hDEADBEEF, err=1, ERR_STATUS.unmapped set.
- Internal registers, offset = address[WIN_BITS-1:2]:
  - 0 IRQ_PENDING (RO) = irq_in.
  - 1 IRQ_ENABLE (RW, byte-enable honoured, bits ≥ NSLAVES read 0).
  - 2 ERR_STATUS: bit0 timeout, bit1 unmapped, bits[15:8] slot of last error. Bits 0/1 are write-1-to-clear. A new error in the same cycle as a clear leaves the bit set. Each new error overwrites the slot field.
  - Other offsets read 0 and ignore writes, with no error.
- irq = |(irq_in & IRQ_ENABLE), registered one cycle.

## Timing
- Reset values: data_out=0, ack=0, err=0, s_read=0, s_write=0, s_address=0, s_writedata=0, s_be=0, irq=0, IRQ_ENABLE=0, ERR_STATUS=0, state IDLE, counter=0.
- Reset is asynchronous. Asserting it mid-ACCESS drops strobes immediately, with no ack.
- External access, ack at first ACCESS cycle: request sampled at cycle 0, strobe at cycle 1, ack at cycle 2. Each wait cycle adds 1.
- Internal or unmapped access: request sampled at cycle 0, ack at cycle 1.
- Timeout: strobe held exactly TIMEOUT cycles; ack/err follow on the next cycle.
- s_* address, data and be are stable for the whole ACCESS. Strobes never assert in IDLE or RESP.
- Back-to-back: the earliest next sample is the IDLE cycle after RESP, which gives a throughput of one external access per 3 cycles.
- s_ack from a non-selected slave is ignored.
- irq lags an irq_in or IRQ_ENABLE change by 1 cycle.

## Test plan
- Read address 0x104 (slot 1) with slave 1 acking after 3 wait cycles and driving 0x12345678 → s_read=4'b0010 for 4 cycles, s_address=0x04, data_out=0x12345678 with ack, err=0, ack 5 cycles after request.
- Write 0xA5A5A5A5 with be=4'b0011 to slot 0, ack in the first ACCESS cycle → s_write=4'b0001 for 1 cycle, s_writedata=0xA5A5A5A5, s_be=4'b0011, ack at cycle 2.
- Read slot 2 with TIMEOUT=255 and no s_ack → strobe high 255 cycles, then ack=1, err=1, data_out=0xDEADBEEF; ERR_STATUS reads 0x00000201.
- Read address 0x500 (slot 5, unmapped) → no strobe, ack at cycle 1, err=1, ERR_STATUS=0x00000502. Write 0x2 to ERR_STATUS → reads 0x00000500.
- Write IRQ_ENABLE=0x5 via 0x704, then drive irq_in=4'b0100 → irq=1 one cycle later. Drive irq_in=4'b0010 → irq=0. IRQ_PENDING read returns 0x2.
- Deassert rst_n while in ACCESS with the strobe high → all strobes drop at once. After release, the state is IDLE and the next read completes normally.
